xbar_route_sequencer: RTL

- Upstream stage of the 4x4 lane crossbar.
- Holds a small queue of route configurations (four 2-bit lane selects plus a beat count).
- Accepts 4-lane input data beats and registers them into a single output stage, each beat stamped with its sel1..sel4 routing.
- The combinational crossbar downstream consumes data_out1..4 and sel1..4 directly; both stay aligned by construction.

---
 rtl/xbar_route_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/xbar_route_sequencer.sv
// xbar_route_sequencer: upstream stage of the 4x4 lane crossbar.
// Queues route configurations (four 2-bit lane selects plus a beat count),
// accepts 4-lane input beats and registers each one into a single output
// stage stamped with the selects of the route entry that governs it, so the
// downstream crossbar always sees data_outN and selN aligned.
// Optional feature macro: XBAR_SEQ_PERF_EN adds the perf_stall_cnt port
// (saturating count of cycles with out_valid && !out_ready).
module xbar_route_sequencer #(
  parameter int BIT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [7:0]             cfg_sel,
  input  logic [CNT_W-1:0]       cfg_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH*4-1:0] in_data1,
  input  logic [BIT_WIDTH*4-1:0] in_data2,
  input  logic [BIT_WIDTH*4-1:0] in_data3,
  input  logic [BIT_WIDTH*4-1:0] in_data4,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH*4-1:0] data_out1,
  output logic [BIT_WIDTH*4-1:0] data_out2,
  output logic [BIT_WIDTH*4-1:0] data_out3,
  output logic [BIT_WIDTH*4-1:0] data_out4,
  output logic [1:0]             sel1,
  output logic [1:0]             sel2,
  output logic [1:0]             sel3,
  output logic [1:0]             sel4,
  output logic                   route_done,
  output logic                   busy
`ifdef XBAR_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam int LW = BIT_WIDTH * 4;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  typedef struct packed {
    logic [7:0]       sel;
    logic [CNT_W-1:0] count;
  } route_t;

  // ---------------------------------------------------------------------------
  // Route configuration FIFO
  // ---------------------------------------------------------------------------
  route_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  route_t          head;

  assign fifo_full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  // Full refuses a push even when the same cycle pops: no pass-through.
  assign cfg_ready  = !fifo_full;
  assign push       = cfg_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q];

  // Entry storage write port.
  // NOTE: the storage array has no reset; only the pointers and occupancy do,
  // so a reset empties the queue without clearing (or building reset logic
  // for) every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{sel: cfg_sel, count: cfg_count};
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally (power of 2).
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO pointer registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Route sequencing FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [7:0]       active_sel_q, active_sel_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             accept;
  logic             out_valid_q;

  // Next-state: load a route in IDLE, stream its beats, chain routes with no
  // bubble when the next entry is already queued.
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    remaining_d  = remaining_q;
    pop          = 1'b0;
    in_ready     = 1'b0;
    accept       = 1'b0;
    route_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          active_sel_d = head.sel;
          remaining_d  = head.count;
          // A zero-count entry is consumed without ever streaming.
          if (head.count != '0) state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            route_done = 1'b1;
            if (!fifo_empty) begin
              pop          = 1'b1;
              active_sel_d = head.sel;
              remaining_d  = head.count;
              if (head.count == '0) state_d = S_IDLE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, active route selects and remaining beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      active_sel_q <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      remaining_q  <= remaining_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [LW-1:0] in_lanes [4];
  logic [LW-1:0] data_q   [4];
  logic [LW-1:0] data_d   [4];
  logic [7:0]    sel_q, sel_d;
  logic          out_valid_d;

  assign in_lanes[0] = in_data1;
  assign in_lanes[1] = in_data2;
  assign in_lanes[2] = in_data3;
  assign in_lanes[3] = in_data4;

  // Load on accept, drop valid once consumed, hold everything while stalled.
  always_comb begin
    data_d      = data_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      data_d      = in_lanes;
      sel_d       = active_sel_q;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers feeding the crossbar.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      for (int i = 0; i < 4; i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign data_out1 = data_q[0];
  assign data_out2 = data_q[1];
  assign data_out3 = data_q[2];
  assign data_out4 = data_q[3];
  assign sel1      = sel_q[1:0];
  assign sel2      = sel_q[3:2];
  assign sel3      = sel_q[5:4];
  assign sel4      = sel_q[7:6];
  assign busy      = !fifo_empty || (state_q == S_STREAM) || out_valid_q;

`ifdef XBAR_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where a held beat is back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
